id_ex_operand_stage: RTL and testbench
======================================

# id_ex_operand_stage

Pipeline stage directly upstream of the 64-bit ALU. It accepts decoded instructions from the decode stage and resolves operand hazards. Operands come from the register file, an EX-stage forward or a WB-stage forward, with a load-use stall when none of these can supply a value in time. The stage registers the ALU inputs `a`, `b` and `alu_opcodes` plus the sideband fields the later stages need, using a valid/ready handshake with stall and flush.

## Interface
- `XLEN`, 64, datapath width.
- `RW`, 5, register index width.

- `clk`  in  1  rising-edge clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  decode holds a valid instruction.
- `in_ready`  out  1  stage accepts the instruction this cycle.
- `in_rs1`, `in_rs2`  in  RW  source register indices.
- `in_rs1_used`, `in_rs2_used`  in  1  the source is actually read.
- `in_rs1_data`, `in_rs2_data`  in  XLEN  register file read data.
- `in_imm`  in  XLEN  sign-extended immediate.
- `in_use_imm`  in  1  select immediate for operand b.
- `in_alu_op`  in  4  ALU opcode, passed through unchanged.
- `in_rd`  in  RW  destination index.
- `in_reg_write`, `in_mem_read`, `in_mem_write`  in  1  control flags.
- `ex_result`  in  XLEN  combinational ALU result for the instruction currently held in this stage.
- `wb_valid`  in  1  WB stage writes the register file this cycle.
- `wb_rd`  in  RW  WB destination index.
- `wb_data`  in  XLEN  WB write data.
- `flush`  in  1  kill the held and incoming instructions.
- `out_ready`  in  1  EX/MEM accepts this stage's output.
- `out_valid`  out  1  output register holds a valid instruction.
- `alu_a`, `alu_b`  out  XLEN  ALU operands a and b.
- `alu_op`  out  4  drives the ALU `alu_opcodes` input.
- `out_store_data`  out  XLEN  forwarded rs2 value, used by stores.
- `out_rd`  out  RW  destination index.
- `out_reg_write`, `out_mem_read`, `out_mem_write`  out  1  control flags.

## Operation
- **Advance condition:** `adv = !out_valid | out_ready`.
- **Load-use hazard:** `hz = out_valid & out_mem_read & out_reg_write & (out_rd != 0) & ((in_rs1_used & in_rs1 == out_rd) | (in_rs2_used & in_rs2 == out_rd))`.
- **Input ready:** `in_ready = flush | (adv & !hz)`.
- **Forward selection, per source, evaluated at capture time:**
  - If the index is 0, the operand is 0.
  - Otherwise EX match (`out_valid & out_reg_write & !out_mem_read & out_rd == rs`) selects `ex_result`.
  - Otherwise WB match (`wb_valid & wb_rd == rs`) selects `wb_data`.
  - Otherwise the register file data is used.
  - EX has priority over WB.
- **Capture, when `adv & !flush`:**
  - `in_valid & !hz` loads the output register: `alu_a` = fwd rs1; `alu_b` = `in_use_imm ? in_imm : fwd rs2`; `out_store_data` = fwd rs2; `alu_op`, `out_rd` and the flags are copied.
  - Otherwise a bubble is inserted: `out_valid` = 0 and all flags = 0. Data fields hold their previous value.
- **Hold:** when `!adv & !flush`, every output register holds.
- **Flush:**
  - Next cycle `out_valid` = 0 and all flags = 0, regardless of `out_ready`.
  - The incoming instruction is consumed (`in_ready` = 1) and discarded.
  - Flush overrides hazard, stall and capture.
- **Reset:** next cycle every output is 0, including the data fields. Reset overrides flush and capture. Reset mid-stall drops the held instruction. `in_ready` after reset is 1.
- Widths are exact. No arithmetic is done in this block. The `rs == 0` test ensures x0 is never forwarded.

## Timing
- Latency is 1 cycle from an accepted input to `out_valid`.
- Throughput is one instruction per cycle when there is no hazard and `out_ready` = 1.
- `in_ready` is combinational from `out_valid`, `out_ready`, `flush` and the hazard compare. It does not depend on `in_valid`.
- A load-use hazard costs exactly one bubble. The load advances and clears `out_mem_read`, so the dependent instruction captures the next cycle. Its load value then arrives via WB forwarding.
- When `in_valid` = 0 and `adv` = 1, a bubble is loaded.
- The output registers change only on the rising edge of `clk`.

## Test plan
- **Back-to-back ALU dependency:**
  - Stimulus: instruction 1 = add rd = 5; instruction 2 = sub rs1 = 5; `ex_result` = 0x1234.
  - Required response: instruction 2 captures `alu_a` = 0x1234 on the next edge with no bubble.
- **Forward priority and x0:**
  - Stimulus A: EX rd = 7 with `ex_result` = 0xAA; WB rd = 7 with `wb_data` = 0xBB.
  - Required response A: `alu_a` = 0xAA.
  - Stimulus B: rs1 = 0 while WB rd = 0 with `wb_data` = 0xFF.
  - Required response B: `alu_a` = 0.
- **Load-use:**
  - Stimulus: a load with rd = 3 is held; the next instruction has rs2 = 3 and `in_rs2_used` = 1.
  - Required response:
    - Cycle 0: `in_ready` = 0 and a bubble is loaded.
    - Cycle 1: the instruction captures with `out_store_data` = `wb_data` (0xDEAD).
  - Stimulus (same scenario, rs2 = 3 but `in_rs2_used` = 0): required response is no stall.
- **Backpressure:**
  - Stimulus: `out_ready` = 0 for 3 cycles with a valid instruction held.
  - Required response: all outputs are stable and `in_ready` = 0. The held instruction leaves on the cycle `out_ready` rises, and the next input captures on that same edge.
- **Flush during stall:**
  - Stimulus: `flush` = 1 while `out_ready` = 0 and a hazard is active.
  - Required response: `in_ready` = 1; next cycle `out_valid` = 0 and `out_reg_write` = 0.
- **Reset:**
  - Stimulus: assert `rst` mid-stream with `alu_a` = 0x55.
  - Required response: next cycle `alu_a` = 0, `out_valid` = 0 and every flag = 0. The first valid input after reset captures normally.

Source files
------------

// File: rtl/id_ex_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex_operand_stage
//  Description : ID/EX pipeline register in front of the 64-bit ALU.
//                Resolves source operands from the register file, an EX-stage
//                forward or a WB-stage forward. Inserts a one-bubble stall on
//                a load-use hazard. Uses a valid/ready handshake with
//                backpressure and flush.
//  Ports       : clk/rst           - clock, synchronous active-high reset
//                in_*_i            - decoded instruction from decode stage
//                in_ready_o        - instruction accepted this cycle
//                ex_result_i       - ALU result of the instruction held here
//                wb_*_i            - WB-stage register file write port
//                flush_i           - kill held and incoming instructions
//                out_ready_i       - downstream accepts the held instruction
//                out_*_o, alu_*_o  - registered ALU operands and sideband
//  Revision    : 1.0 - initial release
// ============================================================================
module id_ex_operand_stage #(
    parameter int XLEN = 64,
    parameter int RW   = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [RW-1:0]   in_rs1_i,
    input  logic [RW-1:0]   in_rs2_i,
    input  logic            in_rs1_used_i,
    input  logic            in_rs2_used_i,
    input  logic [XLEN-1:0] in_rs1_data_i,
    input  logic [XLEN-1:0] in_rs2_data_i,
    input  logic [XLEN-1:0] in_imm_i,
    input  logic            in_use_imm_i,
    input  logic [3:0]      in_alu_op_i,
    input  logic [RW-1:0]   in_rd_i,
    input  logic            in_reg_write_i,
    input  logic            in_mem_read_i,
    input  logic            in_mem_write_i,
    input  logic [XLEN-1:0] ex_result_i,
    input  logic            wb_valid_i,
    input  logic [RW-1:0]   wb_rd_i,
    input  logic [XLEN-1:0] wb_data_i,
    input  logic            flush_i,
    input  logic            out_ready_i,
    output logic            out_valid_o,
    output logic [XLEN-1:0] alu_a_o,
    output logic [XLEN-1:0] alu_b_o,
    output logic [3:0]      alu_op_o,
    output logic [XLEN-1:0] out_store_data_o,
    output logic [RW-1:0]   out_rd_o,
    output logic            out_reg_write_o,
    output logic            out_mem_read_o,
    output logic            out_mem_write_o
);

    // Output register state
    logic            valid_q, valid_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [3:0]      op_q, op_d;
    logic [XLEN-1:0] sd_q, sd_d;
    logic [RW-1:0]   rd_q, rd_d;
    logic            rw_q, rw_d;
    logic            mr_q, mr_d;
    logic            mw_q, mw_d;

    logic            w_adv;
    logic            w_hz;
    logic            w_ex_fwd_ok;
    logic [XLEN-1:0] w_fwd_rs1;
    logic [XLEN-1:0] w_fwd_rs2;

    // Operand source selection. x0 always reads as zero and is never
    // forwarded; EX beats WB because it is the younger producer.
    function automatic logic [XLEN-1:0] fwd_sel(
        input logic [RW-1:0]   rs,
        input logic [XLEN-1:0] rf_data,
        input logic            ex_ok,
        input logic [RW-1:0]   ex_rd,
        input logic [XLEN-1:0] ex_data,
        input logic            wb_ok,
        input logic [RW-1:0]   wb_rd,
        input logic [XLEN-1:0] wb_data
    );
        logic [XLEN-1:0] v;
        if (rs == '0) begin
            v = '0;
        end else if (ex_ok && (ex_rd == rs)) begin
            v = ex_data;
        end else if (wb_ok && (wb_rd == rs)) begin
            v = wb_data;
        end else begin
            v = rf_data;
        end
        return v;
    endfunction

    assign w_adv = !valid_q || out_ready_i;

    // A held load's value is not available from the ALU result, so a
    // dependent reader must wait one cycle and pick it up from WB instead.
    assign w_hz = valid_q && mr_q && rw_q && (rd_q != '0) &&
                  ((in_rs1_used_i && (in_rs1_i == rd_q)) ||
                   (in_rs2_used_i && (in_rs2_i == rd_q)));

    assign in_ready_o = flush_i || (w_adv && !w_hz);

    // Only a non-load ALU producer can forward its combinational result.
    assign w_ex_fwd_ok = valid_q && rw_q && !mr_q;

    assign w_fwd_rs1 = fwd_sel(in_rs1_i, in_rs1_data_i, w_ex_fwd_ok, rd_q,
                               ex_result_i, wb_valid_i, wb_rd_i, wb_data_i);
    assign w_fwd_rs2 = fwd_sel(in_rs2_i, in_rs2_data_i, w_ex_fwd_ok, rd_q,
                               ex_result_i, wb_valid_i, wb_rd_i, wb_data_i);

    always_comb begin
        valid_d = valid_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        sd_d    = sd_q;
        rd_d    = rd_q;
        rw_d    = rw_q;
        mr_d    = mr_q;
        mw_d    = mw_q;
        if (flush_i) begin
            // Kill only the control side; data fields keep their old value.
            valid_d = 1'b0;
            rw_d    = 1'b0;
            mr_d    = 1'b0;
            mw_d    = 1'b0;
        end else if (w_adv) begin
            if (in_valid_i && !w_hz) begin
                valid_d = 1'b1;
                a_d     = w_fwd_rs1;
                b_d     = in_use_imm_i ? in_imm_i : w_fwd_rs2;
                sd_d    = w_fwd_rs2;
                op_d    = in_alu_op_i;
                rd_d    = in_rd_i;
                rw_d    = in_reg_write_i;
                mr_d    = in_mem_read_i;
                mw_d    = in_mem_write_i;
            end else begin
                valid_d = 1'b0;
                rw_d    = 1'b0;
                mr_d    = 1'b0;
                mw_d    = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            sd_q    <= '0;
            rd_q    <= '0;
            rw_q    <= 1'b0;
            mr_q    <= 1'b0;
            mw_q    <= 1'b0;
        end else begin
            valid_q <= valid_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            sd_q    <= sd_d;
            rd_q    <= rd_d;
            rw_q    <= rw_d;
            mr_q    <= mr_d;
            mw_q    <= mw_d;
        end
    end

    assign out_valid_o      = valid_q;
    assign alu_a_o          = a_q;
    assign alu_b_o          = b_q;
    assign alu_op_o         = op_q;
    assign out_store_data_o = sd_q;
    assign out_rd_o         = rd_q;
    assign out_reg_write_o  = rw_q;
    assign out_mem_read_o   = mr_q;
    assign out_mem_write_o  = mw_q;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_id_ex_operand_stage
//  Description : Directed testbench for id_ex_operand_stage with a reference
//                model of the pipeline register checked every cycle, plus
//                hand-computed literal expectations per scenario.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_operand_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [4:0]  in_rs1, in_rs2, in_rd, wb_rd;
    logic        in_rs1_used, in_rs2_used, in_use_imm;
    logic [63:0] in_rs1_data, in_rs2_data, in_imm, ex_result, wb_data;
    logic [3:0]  in_alu_op;
    logic        in_reg_write, in_mem_read, in_mem_write;
    logic        wb_valid, flush, out_ready;
    logic        out_valid;
    logic [63:0] alu_a, alu_b, out_store_data;
    logic [3:0]  alu_op;
    logic [4:0]  out_rd;
    logic        out_reg_write, out_mem_read, out_mem_write;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    id_ex_operand_stage #(.XLEN(64), .RW(5)) dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid_i       (in_valid),
        .in_ready_o       (in_ready),
        .in_rs1_i         (in_rs1),
        .in_rs2_i         (in_rs2),
        .in_rs1_used_i    (in_rs1_used),
        .in_rs2_used_i    (in_rs2_used),
        .in_rs1_data_i    (in_rs1_data),
        .in_rs2_data_i    (in_rs2_data),
        .in_imm_i         (in_imm),
        .in_use_imm_i     (in_use_imm),
        .in_alu_op_i      (in_alu_op),
        .in_rd_i          (in_rd),
        .in_reg_write_i   (in_reg_write),
        .in_mem_read_i    (in_mem_read),
        .in_mem_write_i   (in_mem_write),
        .ex_result_i      (ex_result),
        .wb_valid_i       (wb_valid),
        .wb_rd_i          (wb_rd),
        .wb_data_i        (wb_data),
        .flush_i          (flush),
        .out_ready_i      (out_ready),
        .out_valid_o      (out_valid),
        .alu_a_o          (alu_a),
        .alu_b_o          (alu_b),
        .alu_op_o         (alu_op),
        .out_store_data_o (out_store_data),
        .out_rd_o         (out_rd),
        .out_reg_write_o  (out_reg_write),
        .out_mem_read_o   (out_mem_read),
        .out_mem_write_o  (out_mem_write)
    );

    // ---------------------------------------------------------------- model
    typedef struct {
        bit        valid;
        bit [63:0] a, b, sd;
        bit [3:0]  op;
        bit [4:0]  rd;
        bit        rw, mr, mw;
    } slot_t;

    slot_t m;
    bit    m_ok = 1'b0;

    // Value a source register must have when the consumer captures.
    function automatic bit [63:0] src_value(slot_t s, bit [4:0] rs, bit [63:0] rf);
        if (rs == 0) return 64'd0;
        if (s.valid && s.rw && !s.mr && s.rd == rs) return ex_result;
        if (wb_valid && wb_rd == rs) return wb_data;
        return rf;
    endfunction

    function automatic bit model_stall(slot_t s);
        bit dep;
        dep = (in_rs1_used && in_rs1 == s.rd) || (in_rs2_used && in_rs2 == s.rd);
        return s.valid && s.mr && s.rw && s.rd != 0 && dep;
    endfunction

    function automatic bit model_ready(slot_t s);
        return flush || ((!s.valid || out_ready) && !model_stall(s));
    endfunction

    function automatic slot_t model_next(slot_t s);
        slot_t n;
        slot_t z;
        z = '{default: 0};
        if (rst) return z;
        n = s;
        if (flush || ((!s.valid || out_ready) && !(in_valid && !model_stall(s)))) begin
            n.valid = 0; n.rw = 0; n.mr = 0; n.mw = 0;
        end else if (!s.valid || out_ready) begin
            n.valid = 1;
            n.a  = src_value(s, in_rs1, in_rs1_data);
            n.sd = src_value(s, in_rs2, in_rs2_data);
            n.b  = in_use_imm ? in_imm : n.sd;
            n.op = in_alu_op; n.rd = in_rd;
            n.rw = in_reg_write; n.mr = in_mem_read; n.mw = in_mem_write;
        end
        return n;
    endfunction

    always @(posedge clk) begin
        m <= model_next(m);
        if (rst) m_ok <= 1'b1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the clock edge.
    always @(negedge clk) begin
        if (m_ok) begin
            chk("m.out_valid",  out_valid,      m.valid);
            chk("m.alu_a",      alu_a,          m.a);
            chk("m.alu_b",      alu_b,          m.b);
            chk("m.alu_op",     alu_op,         m.op);
            chk("m.store_data", out_store_data, m.sd);
            chk("m.out_rd",     out_rd,         m.rd);
            chk("m.reg_write",  out_reg_write,  m.rw);
            chk("m.mem_read",   out_mem_read,   m.mr);
            chk("m.mem_write",  out_mem_write,  m.mw);
            chk("m.in_ready",   in_ready,       model_ready(m));
        end
    end

    // ------------------------------------------------------------- stimulus
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 0; in_rs1 = 0; in_rs2 = 0; in_rs1_used = 0; in_rs2_used = 0;
        in_rs1_data = 0; in_rs2_data = 0; in_imm = 0; in_use_imm = 0;
        in_alu_op = 0; in_rd = 0; in_reg_write = 0; in_mem_read = 0;
        in_mem_write = 0; ex_result = 0; wb_valid = 0; wb_rd = 0; wb_data = 0;
        flush = 0; out_ready = 1;
    endtask

    task automatic instr(input logic [4:0] rs1, input logic u1, input logic [63:0] rf1,
                         input logic [4:0] rs2, input logic u2, input logic [63:0] rf2,
                         input logic [4:0] rd, input logic rw, input logic mr,
                         input logic mw, input logic ui, input logic [63:0] imm,
                         input logic [3:0] op);
        in_valid = 1; in_rs1 = rs1; in_rs1_used = u1; in_rs1_data = rf1;
        in_rs2 = rs2; in_rs2_used = u2; in_rs2_data = rf2; in_rd = rd;
        in_reg_write = rw; in_mem_read = mr; in_mem_write = mw;
        in_use_imm = ui; in_imm = imm; in_alu_op = op;
    endtask

    initial begin
        rst = 1;
        idle();
        cyc(); cyc();
        chk("rst.out_valid", out_valid, 0);
        chk("rst.alu_a", alu_a, 0);
        chk("rst.flags", {out_reg_write, out_mem_read, out_mem_write}, 0);
        chk("rst.in_ready", in_ready, 1);
        rst = 0;

        // Back-to-back ALU dependency, with an immediate on operand b.
        instr(5'd1, 1, 64'h10, 5'd2, 1, 64'h20, 5'd5, 1, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFF0, 4'h1);
        cyc();
        chk("b2b.i1.alu_a", alu_a, 64'h10);
        chk("b2b.i1.alu_b", alu_b, 64'hFFFF_FFFF_FFFF_FFF0);
        chk("b2b.i1.store", out_store_data, 64'h20);
        instr(5'd5, 1, 64'h999, 5'd0, 0, 0, 5'd6, 1, 0, 0, 0, 0, 4'h2);
        ex_result = 64'h1234;
        #1 chk("b2b.i2.in_ready", in_ready, 1);
        cyc();
        chk("b2b.i2.alu_a", alu_a, 64'h1234);
        chk("b2b.i2.valid", out_valid, 1);

        // Forward priority EX over WB, then x0 never forwarded.
        instr(5'd0, 0, 0, 5'd0, 0, 0, 5'd7, 1, 0, 0, 0, 0, 4'h0);
        cyc();
        instr(5'd7, 1, 64'h99, 5'd0, 0, 0, 5'd8, 0, 0, 0, 0, 0, 4'h0);
        ex_result = 64'hAA; wb_valid = 1; wb_rd = 5'd7; wb_data = 64'hBB;
        cyc();
        chk("prio.alu_a", alu_a, 64'hAA);
        instr(5'd0, 1, 64'h77, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 0, 4'h0);
        wb_rd = 5'd0; wb_data = 64'hFF;
        cyc();
        chk("x0.alu_a", alu_a, 64'h0);
        wb_valid = 0;

        // Load-use: one bubble, then WB forward supplies the load value.
        instr(5'd1, 1, 64'h100, 5'd0, 0, 0, 5'd3, 1, 1, 0, 0, 0, 4'h0);
        cyc();
        instr(5'd4, 1, 64'h40, 5'd3, 1, 64'h1, 5'd9, 1, 0, 1, 0, 0, 4'h0);
        ex_result = 64'hBAD;
        #1 chk("lu.in_ready.c0", in_ready, 0);
        cyc();
        chk("lu.bubble.valid", out_valid, 0);
        chk("lu.bubble.mem_read", out_mem_read, 0);
        wb_valid = 1; wb_rd = 5'd3; wb_data = 64'hDEAD;
        #1 chk("lu.in_ready.c1", in_ready, 1);
        cyc();
        chk("lu.store", out_store_data, 64'hDEAD);
        chk("lu.alu_a", alu_a, 64'h40);
        chk("lu.valid", out_valid, 1);
        wb_valid = 0;

        // Same shape but rs2 not read: no stall.
        instr(5'd0, 0, 0, 5'd0, 0, 0, 5'd3, 1, 1, 0, 0, 0, 4'h0);
        cyc();
        instr(5'd0, 0, 0, 5'd3, 0, 64'h22, 5'd12, 1, 0, 0, 0, 0, 4'h3);
        #1 chk("lu_unused.in_ready", in_ready, 1);
        cyc();
        chk("lu_unused.valid", out_valid, 1);
        chk("lu_unused.store", out_store_data, 64'h22);

        // Backpressure for three cycles.
        out_ready = 0;
        instr(5'd1, 1, 64'h31, 5'd0, 0, 0, 5'd10, 1, 0, 0, 0, 0, 4'h5);
        for (int i = 0; i < 3; i++) begin
            #1 chk("bp.in_ready", in_ready, 0);
            cyc();
            chk("bp.valid", out_valid, 1);
            chk("bp.store", out_store_data, 64'h22);
            chk("bp.rd", out_rd, 5'd12);
            chk("bp.op", alu_op, 4'h3);
        end
        out_ready = 1;
        #1 chk("bp.release.in_ready", in_ready, 1);
        cyc();
        chk("bp.next.alu_a", alu_a, 64'h31);
        chk("bp.next.rd", out_rd, 5'd10);

        // Flush while stalled on a hazard.
        instr(5'd0, 0, 0, 5'd0, 0, 0, 5'd3, 1, 1, 0, 0, 0, 4'h0);
        cyc();
        out_ready = 0; flush = 1;
        instr(5'd3, 1, 0, 5'd0, 0, 0, 5'd13, 1, 0, 0, 0, 0, 4'h0);
        #1 chk("fl.in_ready", in_ready, 1);
        cyc();
        chk("fl.valid", out_valid, 0);
        chk("fl.reg_write", out_reg_write, 0);
        chk("fl.mem_read", out_mem_read, 0);
        flush = 0; out_ready = 1;

        // Reset mid-stream.
        instr(5'd1, 1, 64'h55, 5'd0, 0, 0, 5'd11, 1, 0, 0, 0, 0, 4'h0);
        cyc();
        chk("rs.pre.alu_a", alu_a, 64'h55);
        rst = 1;
        cyc();
        chk("rs.alu_a", alu_a, 0);
        chk("rs.valid", out_valid, 0);
        chk("rs.flags", {out_reg_write, out_mem_read, out_mem_write}, 0);
        chk("rs.in_ready", in_ready, 1);
        rst = 0;
        instr(5'd1, 1, 64'h66, 5'd0, 0, 0, 5'd14, 1, 0, 0, 0, 0, 4'h0);
        cyc();
        chk("rs.after.alu_a", alu_a, 64'h66);
        chk("rs.after.valid", out_valid, 1);

        // No input with advance allowed: bubble, data held.
        idle();
        cyc();
        chk("idle.valid", out_valid, 0);
        chk("idle.alu_a", alu_a, 64'h66);
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire
